// File: rtl/shift_pkg.sv
// ============================================================================
// Module  : shift_pkg
// Brief   : Shared status-bit indices and FSM state type for the shift units.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam int ST_NEG_B    = 0;
    localparam int ST_PARITY   = 1;
    localparam int ST_ALL_ONES = 2;
    localparam int ST_OVF      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLAG  = 2'd2
    } shift_state_t;

endpackage

`default_nettype wire

// File: rtl/shift_status_flags.sv
// ============================================================================
// Module  : shift_status_flags
// Brief   : Combinational 4-bit status encoder shared by the shift units.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_status_flags
    import shift_pkg::*;
#(
    parameter int m = 8
) (
    input  logic [m-1:0] i_result,
    input  logic         i_neg_b,
    input  logic         i_ovf,
    output logic [3:0]   o_status
);

    logic w_all_ones;
    logic w_even_nz;

    assign w_all_ones = &i_result;
    // Parity flag deliberately excludes zero, which also has even popcount.
    assign w_even_nz  = (~^i_result) & (|i_result);

    always_comb begin
        o_status              = 4'b0000;
        o_status[ST_NEG_B]    = i_neg_b;
        o_status[ST_PARITY]   = w_even_nz;
        o_status[ST_ALL_ONES] = w_all_ones;
        o_status[ST_OVF]      = i_ovf;
    end

endmodule

`default_nettype wire

// File: rtl/left_shift_seq.sv
// ============================================================================
// Module  : left_shift_seq
// Brief   : Sequential left shifter, one bit per clock, start/done handshake.
//           Optional operand inversion under LEFT_SHIFT_INVERT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module left_shift_seq
    import shift_pkg::*;
#(
    parameter int m = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [m-1:0] i_arg_A,
    input  logic [m-1:0] i_arg_B,
    output logic         o_busy,
    output logic         o_done,
    output logic [m-1:0] o_newA,
    output logic [3:0]   o_status
);

    localparam int CW = $clog2(m + 1);

    shift_state_t  r_state;
    logic [m-1:0]  r_opnd;
    logic [CW-1:0] r_cnt;
    logic          r_lost;
    logic          r_neg;
    logic          r_busy;
    logic          r_done;
    logic [m-1:0]  r_newA;
    logic [3:0]    r_status;

    logic [m-1:0]  w_opnd_in;
    logic          w_b_big;
    logic [CW-1:0] w_cnt_init;
    logic [m-1:0]  w_result;
    logic          w_ovf;
    logic [3:0]    w_status;

`ifdef LEFT_SHIFT_INVERT_EN
    assign w_opnd_in = ~i_arg_A;
`else
    assign w_opnd_in = i_arg_A;
`endif

    // Shift counts of m or more saturate; negative counts mean no shifting.
    assign w_b_big    = ({1'b0, i_arg_B} >= (m + 1)'(m));
    assign w_cnt_init = i_arg_B[m-1] ? '0 :
                        w_b_big      ? CW'(m) :
                                       i_arg_B[CW-1:0];

    assign w_result = (r_neg || r_lost) ? '0 : r_opnd;
    assign w_ovf    = ~r_neg & r_lost;

    shift_status_flags #(
        .m (m)
    ) u_flags (
        .i_result (w_result),
        .i_neg_b  (r_neg),
        .i_ovf    (w_ovf),
        .o_status (w_status)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_lost   <= 1'b0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_newA   <= '0;
            r_status <= 4'b0000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_opnd  <= w_opnd_in;
                        r_cnt   <= w_cnt_init;
                        r_lost  <= 1'b0;
                        r_neg   <= i_arg_B[m-1];
                        r_busy  <= 1'b1;
                        r_state <= (w_cnt_init == '0) ? FLAG : SHIFT;
                    end
                end
                SHIFT: begin
                    r_opnd <= {r_opnd[m-2:0], 1'b0};
                    r_lost <= r_lost | r_opnd[m-1];
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= FLAG;
                    end
                end
                FLAG: begin
                    r_newA   <= w_result;
                    r_status <= w_status;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_newA   = r_newA;
    assign o_status = r_status;

endmodule

`default_nettype wire

// File: tb/tb_left_shift_seq.sv
// ============================================================================
// Module  : tb_left_shift_seq
// Brief   : Directed self-checking bench for left_shift_seq (m = 8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_left_shift_seq;

`ifdef LEFT_SHIFT_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] arg_a;
    logic [7:0] arg_b;
    logic       busy;
    logic       done;
    logic [7:0] new_a;
    logic [3:0] status;

    int n_vec;
    int n_err;

    left_shift_seq #(
        .m (8)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_arg_A  (arg_a),
        .i_arg_B  (arg_b),
        .o_busy   (busy),
        .o_done   (done),
        .o_newA   (new_a),
        .o_status (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check busy, done latency and results.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_a, input logic [3:0] exp_st,
                          input int exp_lat, input bit intrude);
        int k;
        bit seen;
        @(negedge clk);
        arg_a = a;
        arg_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".busy0"}, int'(busy), 1);
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        k     = 0;
        while (!seen && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (done) seen = 1'b1;
            start = intrude && (k == 2);
            if (intrude && k == 2) begin
                arg_a = 8'h00;
                arg_b = 8'h00;
            end
        end
        start = 1'b0;
        chk({tag, ".latency"}, seen ? k : -1, exp_lat);
        chk({tag, ".newA"}, int'(new_a), int'(exp_a));
        chk({tag, ".status"}, int'(status), int'(exp_st));
        chk({tag, ".busy_end"}, int'(busy), 0);
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, int'(done), 0);
        chk({tag, ".hold"}, int'(new_a), int'(exp_a));
    endtask

    initial begin
        int extra;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        arg_a = 8'h00;
        arg_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.newA", int'(new_a), 0);
        chk("rst.status", int'(status), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("f0_b2", 8'hF0, 8'd2, INV ? 8'h3C : 8'h00, INV ? 4'b0010 : 4'b1000, 3, 1'b0);
        run_op("0f_b2", 8'h0F, 8'd2, INV ? 8'h00 : 8'h3C, INV ? 4'b1000 : 4'b0010, 3, 1'b0);
        run_op("00_b0", 8'h00, 8'd0, INV ? 8'hFF : 8'h00, INV ? 4'b0110 : 4'b0000, 1, 1'b0);
        run_op("ff_b0", 8'hFF, 8'd0, INV ? 8'h00 : 8'hFF, INV ? 4'b0000 : 4'b0110, 1, 1'b0);
        run_op("negb", 8'h5A, 8'hFF, 8'h00, 4'b0001, 1, 1'b0);
        run_op("sat_b20", 8'hFF, 8'd20, 8'h00, INV ? 4'b0000 : 4'b1000, 9, 1'b1);

        // The intruding start must not have been queued.
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        chk("sat.no_queue", extra, 0);

        run_op("03_b3", 8'h03, 8'd3, INV ? 8'h00 : 8'h18, INV ? 4'b1000 : 4'b0010, 4, 1'b0);
        run_op("fe_b7", 8'hFE, 8'd7, INV ? 8'h80 : 8'h00, INV ? 4'b0000 : 4'b1000, 8, 1'b0);
        // Leave a nonzero result in place before the abort test.
        run_op("c3_b1", 8'hC3, 8'd1, INV ? 8'h78 : 8'h00, INV ? 4'b0010 : 4'b1000, 2, 1'b0);

        @(negedge clk);
        arg_a = 8'hF0;
        arg_b = 8'd5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort.busy", int'(busy), 0);
        chk("abort.done", int'(done), 0);
        chk("abort.newA", int'(new_a), 0);
        chk("abort.status", int'(status), 0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) extra++;
        end
        chk("abort.no_done", extra, 0);

        run_op("post_rst", 8'hF0, 8'd2, INV ? 8'h3C : 8'h00, INV ? 4'b0010 : 4'b1000, 3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
